i2s_tx_serializer: RTL and testbench

//  I2S master transmitter: takes stereo PCM sample pairs over a valid/ready handshake.

---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_clk_gen.sv | 50 +++++
 rtl/i2s_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg
// Shared constants for the I2S transmit path: default sample and slot widths,
// the LRCK encoding of the two channel slots, and the frame length in BCLK
// periods (one left slot followed by one right slot).
package i2s_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int SLOT_W_DEF    = 32;
  localparam int BCLK_HALF_DEF = 2;

  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  localparam int FRAME_LEN_DEF = 2 * SLOT_W_DEF;

  // Frame length for an arbitrary slot width.
  function automatic int frame_len(input int slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen
// Divides the system clock down to the I2S bit clock and flags the CLK cycle
// in which BCLK is about to change, so downstream registers can update in
// lock-step with the BCLK edge they belong to.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   1=run; 0=divider held at 0 and BCLK held low
//   bclk       out  registered bit clock
//   bclk_fall  out  high in the CLK cycle whose edge takes BCLK 1->0
//   bclk_rise  out  high in the CLK cycle whose edge takes BCLK 0->1
module i2s_clk_gen #(
  parameter int BCLK_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic bclk,
  output logic bclk_fall,
  output logic bclk_rise
);

  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             div_tc;

  assign div_tc = (div_cnt == DIV_W'(BCLK_HALF - 1));

  // The strobes are decoded from the current BCLK level so they coincide with
  // the CLK edge that actually flips BCLK.
  assign bclk_fall = enable & div_tc & bclk;
  assign bclk_rise = enable & div_tc & ~bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
// I2S master transmitter. Stereo sample pairs arrive over valid/ready into a
// one-deep holding register; at every frame boundary the held pair (or
// silence, if nothing is held) moves into the output word registers and is
// sent MSB first, one BCLK after the LRCK edge, zero padded to the slot end.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   1=run; 0=idle with BCLK low and counters at reset
//   s_valid      in   sample pair offered
//   s_ready      out  holding register empty
//   s_left       in   left sample, two's complement
//   s_right      in   right sample, two's complement
//   bclk         out  bit clock
//   lrck         out  0=left slot, 1=right slot
//   aud_out      out  serial data to the DAC (also the loopback source)
//   frame_start  out  1-CLK pulse when a frame's left slot begins
//   underrun     out  1-CLK pulse when a frame starts with nothing held
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SLOT_W    = SLOT_W_DEF,
  parameter int BCLK_HALF = BCLK_HALF_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bclk,
  output logic              lrck,
  output logic              aud_out,
  output logic              frame_start,
  output logic              underrun
);

  localparam int FRAME_LEN = frame_len(SLOT_W);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              bclk_fall;
  logic              bclk_rise_unused;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_nxt;
  logic [CNT_W-1:0]  slot_pos;
  logic [IDX_W-1:0]  bit_idx;
  logic              next_right;
  logic              next_aud;
  logic              frame_load;
  logic              transfer;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_left;
  logic [DATA_W-1:0] hold_right;
  logic [DATA_W-1:0] left_word;
  logic [DATA_W-1:0] right_word;

  // Data launches on the falling BCLK edge, so the rise strobe has no user here.
  i2s_clk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .bclk      (bclk),
    .bclk_fall (bclk_fall),
    .bclk_rise (bclk_rise_unused)
  );

  assign s_ready    = ~hold_valid;
  assign transfer   = s_valid & ~hold_valid;
  assign frame_load = bclk_fall & (bit_cnt == CNT_W'(FRAME_LEN - 1));

  // Select the bit for the upcoming BCLK period. Slot position 0 is the
  // I2S delay bit, 1..DATA_W carry the word MSB first, the rest is padding.
  // Position 0 is also where a frame load lands, so the freshly loaded words
  // are never read in the cycle they are written.
  always_comb begin
    bit_cnt_nxt = (bit_cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : bit_cnt + 1'b1;
    next_right  = (bit_cnt_nxt >= CNT_W'(SLOT_W));
    slot_pos    = next_right ? bit_cnt_nxt - CNT_W'(SLOT_W) : bit_cnt_nxt;
    bit_idx     = IDX_W'(DATA_W - int'(slot_pos));
    next_aud    = 1'b0;
    if (slot_pos != '0 && slot_pos <= CNT_W'(DATA_W)) begin
      next_aud = next_right ? right_word[bit_idx] : left_word[bit_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= CNT_W'(FRAME_LEN - 1);
      lrck       <= LRCK_RIGHT;
      aud_out    <= 1'b0;
      left_word  <= '0;
      right_word <= '0;
    end else if (!enable) begin
      bit_cnt    <= CNT_W'(FRAME_LEN - 1);
      lrck       <= LRCK_RIGHT;
      aud_out    <= 1'b0;
    end else if (bclk_fall) begin
      bit_cnt <= bit_cnt_nxt;
      lrck    <= next_right ? LRCK_RIGHT : LRCK_LEFT;
      aud_out <= next_aud;
      if (frame_load) begin
        left_word  <= hold_valid ? hold_left  : '0;
        right_word <= hold_valid ? hold_right : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= frame_load;
      underrun    <= frame_load & ~hold_valid;
    end
  end

  // A transfer can only happen while the register is empty and a load only
  // drains it while full, so the two never compete for hold_valid. A pair
  // arriving on the load cycle therefore waits for the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_left  <= '0;
      hold_right <= '0;
    end else if (transfer) begin
      hold_valid <= 1'b1;
      hold_left  <= s_left;
      hold_right <= s_right;
    end else if (frame_load && hold_valid) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer
// Drives the serializer through reset, steady streaming, underruns, a pair
// arriving on the load cycle, asynchronous reset with a pair held, an enable
// gap, and a random valid pattern. Expected outputs come from a time-based
// model: BCLK phase, bit position and frame boundaries are derived from the
// number of enabled CLK edges, and a small queue-like holding model decides
// which pair each frame carries.
module tb_i2s_tx_serializer;

  localparam int DATA_W    = 16;
  localparam int SLOT_W    = 32;
  localparam int BH        = 2;
  localparam int FRAME_LEN = 2 * SLOT_W;
  localparam int FALL_CLK  = 2 * BH;
  localparam int FRAME_CLK = FRAME_LEN * FALL_CLK;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;
  logic              bclk;
  logic              lrck;
  logic              aud_out;
  logic              frame_start;
  logic              underrun;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                t;
  logic              m_hold;
  logic [DATA_W-1:0] m_hl, m_hr;
  logic [DATA_W-1:0] m_wl, m_wr;
  logic              m_fs, m_ur;

  logic [DATA_W-1:0] pl, pr;
  logic              took;

  i2s_tx_serializer #(
    .DATA_W    (DATA_W),
    .SLOT_W    (SLOT_W),
    .BCLK_HALF (BH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_left      (s_left),
    .s_right     (s_right),
    .bclk        (bclk),
    .lrck        (lrck),
    .aud_out     (aud_out),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic resetModel();
    t      = 0;
    m_hold = 1'b0;
    m_hl   = '0;
    m_hr   = '0;
    m_wl   = '0;
    m_wr   = '0;
    m_fs   = 1'b0;
    m_ur   = 1'b0;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b t=%0d", tag, obs, exp, t);
    end
  endtask

  // Expected outputs follow from the count of enabled edges: BCLK flips every
  // BH edges, every 2*BH edges is a falling edge that advances one bit.
  task automatic checkOutput();
    int                n, bitpos, p;
    logic              e_bclk, e_lrck, e_aud;
    logic [DATA_W-1:0] w;
    e_bclk = ((t / BH) % 2) == 1;
    n      = t / FALL_CLK;
    e_lrck = 1'b1;
    e_aud  = 1'b0;
    if (n > 0) begin
      bitpos = (n - 1) % FRAME_LEN;
      e_lrck = (bitpos >= SLOT_W);
      p      = bitpos % SLOT_W;
      w      = e_lrck ? m_wr : m_wl;
      if (p >= 1 && p <= DATA_W) e_aud = w[4'(DATA_W - p)];
    end
    checkBit("s_ready", s_ready, ~m_hold);
    checkBit("bclk", bclk, e_bclk);
    checkBit("lrck", lrck, e_lrck);
    checkBit("aud_out", aud_out, e_aud);
    checkBit("frame_start", frame_start, m_fs);
    checkBit("underrun", underrun, m_ur);
  endtask

  // Advance the model across one CLK edge using the inputs now applied, then
  // let the edge happen and compare.
  task automatic advance();
    int   tn;
    logic ld, xfer;
    if (!rst_n) begin
      resetModel();
    end else begin
      xfer = s_valid && !m_hold;
      if (enable) begin
        tn = t + 1;
        ld = (tn >= FALL_CLK) && (((tn - FALL_CLK) % FRAME_CLK) == 0);
      end else begin
        tn = 0;
        ld = 1'b0;
      end
      m_fs = ld;
      m_ur = ld && !m_hold;
      if (ld) begin
        if (m_hold) begin
          m_wl   = m_hl;
          m_wr   = m_hr;
          m_hold = 1'b0;
        end else begin
          m_wl = '0;
          m_wr = '0;
        end
      end
      if (xfer) begin
        m_hold = 1'b1;
        m_hl   = s_left;
        m_hr   = s_right;
      end
      t = tn;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] l,
                               input logic [DATA_W-1:0] r);
    s_valid = v;
    s_left  = l;
    s_right = r;
    advance();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 16'($urandom), 16'($urandom));
  endtask

  // Asynchronous reset between clock edges, checked before any edge arrives.
  task automatic pulseReset();
    rst_n = 1'b0;
    #2;
    resetModel();
    checkOutput();
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b1;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_left  = '0;
    s_right = '0;
    #1;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput();
    idle(2);
    rst_n  = 1'b1;
    enable = 1'b1;

    $display("[TB] phase 1: single pair A5C3/0F01");
    applyStimulus(1'b1, 16'hA5C3, 16'h0F01);
    idle(2 * FRAME_CLK);

    $display("[TB] phase 2: no valid, repeated underruns");
    pulseReset();
    idle(3 * FRAME_CLK);

    $display("[TB] phase 3: valid held high, incrementing pairs");
    pulseReset();
    pl = 16'($urandom);
    pr = 16'($urandom);
    for (int i = 0; i < 4 * FRAME_CLK + 20; i++) begin
      took = !m_hold;
      applyStimulus(1'b1, pl, pr);
      if (took) begin
        pl = pl + 1'b1;
        pr = pr + 1'b1;
      end
    end

    $display("[TB] phase 4: pair arrives on the load cycle");
    pulseReset();
    idle(FALL_CLK - 1);
    applyStimulus(1'b1, 16'($urandom), 16'($urandom));
    idle(2 * FRAME_CLK + 8);

    $display("[TB] phase 5: reset mid left slot with a pair held");
    pulseReset();
    applyStimulus(1'b1, 16'($urandom), 16'($urandom));
    idle(90);
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF);
    idle(10);
    pulseReset();
    idle(2 * FRAME_CLK + 8);

    $display("[TB] phase 6: enable low for 100 CLK mid-frame");
    pulseReset();
    idle(150);
    enable = 1'b0;
    idle(10);
    applyStimulus(1'b1, 16'($urandom), 16'($urandom));
    idle(89);
    enable = 1'b1;
    idle(FRAME_CLK + 40);

    $display("[TB] phase 7: random valid pattern");
    for (int i = 0; i < 6 * FRAME_CLK; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, 16'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
